// File: rtl/arb_req_queue.sv
// Three per-requester FIFOs feeding a downstream 3-way arbiter.
// A one-hot grant pops the granted queue's head onto a registered output port.
module arb_req_queue #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          in_valid,
  input  logic [3*DATA_W-1:0] in_data,
  output logic [2:0]          in_ready,
  output logic [2:0]          req,
  input  logic [2:0]          gnt,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_data,
  output logic [1:0]          out_id,
  output logic                err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_q [3][DEPTH];

  logic [PW-1:0] head_q  [3];
  logic [PW-1:0] head_d  [3];
  logic [PW-1:0] tail_q  [3];
  logic [PW-1:0] tail_d  [3];
  logic [CW-1:0] count_q [3];
  logic [CW-1:0] count_d [3];

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic [1:0]        out_id_q,    out_id_d;
  logic              err_q,       err_d;

  logic [2:0] push;
  logic [2:0] pop;
  logic [1:0] pop_idx;
  logic       gnt_onehot;
  logic       pop_ok;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    pop_idx    = 2'd0;
    gnt_onehot = (gnt == 3'b001) || (gnt == 3'b010) || (gnt == 3'b100);
    case (gnt)
      3'b010:  pop_idx = 2'd1;
      3'b100:  pop_idx = 2'd2;
      default: pop_idx = 2'd0;
    endcase
    pop_ok = gnt_onehot && (count_q[pop_idx] != '0);

    push     = '0;
    pop      = '0;
    in_ready = '0;
    req      = '0;
    for (int i = 0; i < 3; i++) begin
      in_ready[i] = count_q[i] < CW'(DEPTH);
      // The last entry stops requesting while its grant is already in flight.
      req[i]      = (count_q[i] >= CW'(2)) || ((count_q[i] == CW'(1)) && !gnt[i]);
      push[i]     = in_valid[i] && in_ready[i];
      pop[i]      = pop_ok && (pop_idx == 2'(i));

      head_d[i]  = pop[i]  ? head_q[i] + PW'(1) : head_q[i];
      tail_d[i]  = push[i] ? tail_q[i] + PW'(1) : tail_q[i];
      count_d[i] = count_q[i];
      if (push[i] && !pop[i]) count_d[i] = count_q[i] + CW'(1);
      if (pop[i] && !push[i]) count_d[i] = count_q[i] - CW'(1);
    end

    out_valid_d = pop_ok;
    out_data_d  = pop_ok ? mem_q[pop_idx][head_q[pop_idx]] : out_data_q;
    out_id_d    = pop_ok ? pop_idx : out_id_q;
    err_d       = err_q || ((gnt != 3'b000) && !pop_ok);
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        head_q[i]  <= '0;
        tail_q[i]  <= '0;
        count_q[i] <= '0;
      end
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= 2'd0;
      err_q       <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        head_q[i]  <= head_d[i];
        tail_q[i]  <= tail_d[i];
        count_q[i] <= count_d[i];
      end
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      err_q       <= err_d;
    end
  end

  // NOTE: the payload array has no reset; stale words are unreachable once counts are zero.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (push[i]) mem_q[i][tail_q[i]] <= in_data[i*DATA_W +: DATA_W];
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
  assign err       = err_q;

endmodule

// File: doc/arb_req_queue.md
ARB_REQ_QUEUE -- requirements
Module: arb_req_queue

Interface
REQ-001 SHALL have parameter DATA_W, default 8: payload width per requester.
REQ-002 SHALL have parameter DEPTH, default 4: entries per requester queue, power of two, >=2.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  3  per-requester push strobe; bit i is requester i.
REQ-006 in_data  input  3*DATA_W  payloads; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-007 in_ready  output  3  per-requester space available.
REQ-008 req  output  3  request vector to the downstream 3-way round-robin arbiter.
REQ-009 gnt  input  3  registered one-hot grant from that arbiter; 000 means no grant.
REQ-010 out_valid  output  1  granted payload valid, one-cycle pulse per pop.
REQ-011 out_data  output  DATA_W  granted payload.
REQ-012 out_id  output  2  index (0..2) of the requester that out_data came from.
REQ-013 err  output  1  sticky protocol-error flag.

Function
REQ-014 Three independent FIFOs, one per requester, DEPTH entries each, with a count of 0..DEPTH.
REQ-015 in_ready[i] = (count_i < DEPTH), combinational from registered count, with no pop look-ahead.
REQ-016 Push on queue i when in_valid[i] && in_ready[i]; writes in_data slice i at the tail.
REQ-017 in_valid[i] while !in_ready[i] is dropped silently, with no state change and no err.
REQ-018 req[i] = (count_i >= 2) || (count_i == 1 && !gnt[i]), so the last entry is not re-requested while its grant is in flight.
REQ-019 Valid pop: gnt is one-hot with bit i set and count_i >= 1; pops head of queue i.
REQ-020 On a valid pop, the next cycle shows out_valid=1, out_data=popped head, out_id=i; otherwise the next cycle shows out_valid=0.
REQ-021 out_data and out_id hold their last values while out_valid=0.
REQ-022 Pop latency is 1 cycle from gnt to out_valid; there is no downstream backpressure.
REQ-023 Same-cycle push and pop on one queue: count unchanged, both take effect; on an empty queue the pop is invalid (REQ-024) and the push still occurs.
REQ-024 Grant to an empty queue: no pop, out_valid=0 next cycle, err set.
REQ-025 Multi-hot gnt: no pop on any queue, out_valid=0 next cycle, err set.
REQ-026 err, once set, stays 1 until rst.
REQ-027 Head and tail pointers wrap modulo DEPTH; count arithmetic never under/overflows.
REQ-028 Pushes on different queues are independent and may all occur in the same cycle.
REQ-029 FIFO order is preserved per requester; no ordering is guaranteed across requesters.

Reset
REQ-030 While rst=1 at a posedge: all counts and pointers 0, out_valid=0, out_data=0, out_id=0, err=0.
REQ-031 With counts 0 after reset: req=000 and in_ready=111.
REQ-032 rst mid-operation discards all queued entries and any in-flight pop; gnt and in_valid are ignored while rst=1.
REQ-033 Stored data array is not required to be cleared by reset.

Verification
REQ-034 Push A0,A1 to queue 0; gnt=001 for two cycles -> out_valid for two cycles with out_data A0 then A1 and out_id=0; req[0] drops in the cycle the second gnt is high.
REQ-035 Fill queue 1 with DEPTH entries -> in_ready[1]=0; a further push is dropped; DEPTH pops return the entries in order; count returns to 0.
REQ-036 With the real rr arbiter attached, all queues loaded with 3 entries -> grants rotate 0,1,2,0,1,2,...; 9 pops total, no err, per-id order preserved.
REQ-037 Queue 2 empty, drive gnt=100 -> out_valid=0 next cycle, err=1 and it persists; drive gnt=011 -> no pop.
REQ-038 Queue 0 holds 1 entry; push and gnt=001 in the same cycle -> count stays 1, popped value is the old head.
REQ-039 rst asserted with entries queued and gnt high -> next cycle out_valid=0, req=000, in_ready=111, err=0.
